// File: rtl/conv_pkg.sv
// Shared definitions for the 25-tap convolution scheduler: FSM state
// encoding and kernel geometry constants.
package conv_pkg;

    localparam int KSIZE = 5;               // kernel is KSIZE x KSIZE
    localparam int TAPS  = KSIZE * KSIZE;   // taps per window
    localparam int TAP_W = 8;               // bits per tap / pixel
    localparam int CNT_W = 5;               // fetch counter width, holds 0..TAPS
    localparam int RC_W  = 3;               // kernel row/column index width

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CONV,
        WRITE,
        ADVANCE,
        FINISH
    } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Window address generator: maps window origin (x,y) plus kernel offset
// (r,c) to a source pixel address, and (x,y) to the destination address
// in the (IMG_W-4)-wide interior output image.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    input  logic [RC_W-1:0]   r,
    input  logic [RC_W-1:0]   c,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    // Row-major addressing in both source and destination images
    always_comb begin
        rd_addr = (y + ADDR_W'(r)) * ADDR_W'(IMG_W) + x + ADDR_W'(c);
        wr_addr = y * ADDR_W'(IMG_W - 4) + x;
    end

endmodule

// File: rtl/conv_scheduler.sv
// Convolution scheduler: walks every interior 5x5 window of an IMG_W x IMG_H
// image, gathers the 25 pixels, hands them with the latched filter to an
// external convolution unit, and writes each result to destination memory.
// Optional build macro CONV_SCHED_NEG_CLAMP_EN: negative results are written
// as 0 instead of their saturated magnitude.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [TAPS*TAP_W-1:0]    filter_in,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [TAP_W-1:0]         rd_data,
    output logic [TAPS*TAP_W-1:0]    conv_a,
    output logic [TAPS*TAP_W-1:0]    conv_b,
    output logic                     conv_start,
    input  logic                     conv_done,
    input  logic [TAP_W-1:0]         conv_result,
    input  logic                     conv_sign,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [TAP_W-1:0]         wr_data,
    output logic                     busy,
    output logic                     done_all
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 5);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 5);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(TAPS);
    localparam logic [RC_W-1:0]   C_LAST = RC_W'(KSIZE - 1);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [RC_W-1:0]          r_q, r_d, c_q, c_d;
    logic [TAPS*TAP_W-1:0]    conv_a_q, conv_a_d, conv_b_q, conv_b_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [TAP_W-1:0]         wr_data_q, wr_data_d;
    logic                     conv_start_q, conv_start_d;
    logic                     busy_q, busy_d;
    logic                     done_all_q, done_all_d;
    logic [ADDR_W-1:0]        gen_rd_addr, gen_wr_addr;
    logic [TAP_W-1:0]         result_val;

    // Addresses are generated from next-state coordinates so that the
    // registered rd_addr/wr_addr line up with rd_en/wr_en.
    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .x       (x_d),
        .y       (y_d),
        .r       (r_d),
        .c       (c_d),
        .rd_addr (gen_rd_addr),
        .wr_addr (gen_wr_addr)
    );

`ifdef CONV_SCHED_NEG_CLAMP_EN
    // Negative sums are clamped to zero
    always_comb result_val = conv_sign ? '0 : conv_result;
`else
    // Magnitude output; the sign flag has no effect in this build
    logic unused_conv_sign;
    always_comb unused_conv_sign = conv_sign;
    always_comb result_val = conv_result;
`endif

    // Next-state and next-output computation for the window-walking FSM
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        conv_a_d   = conv_a_q;
        conv_b_d   = conv_b_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_all_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    conv_b_d = filter_in;
                    x_d      = '0;
                    y_d      = '0;
                    cnt_d    = '0;
                    r_d      = '0;
                    c_d      = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // Data for tap cnt-1 arrives one cycle after its read
                if (cnt_q != '0) begin
                    conv_a_d[{cnt_q - CNT_W'(1), 3'b000} +: TAP_W] = rd_data;
                end
                if (cnt_q == CNT_END) begin
                    state_d = CONV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        r_d = r_q + RC_W'(1);
                    end else begin
                        c_d = c_q + RC_W'(1);
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = gen_wr_addr;
                    wr_data_d = result_val;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                state_d = ADVANCE;
            end
            ADVANCE: begin
                cnt_d = '0;
                r_d   = '0;
                c_d   = '0;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        done_all_d = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        y_d     = y_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    x_d     = x_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered strobes derived from where the FSM goes next
        rd_en_d      = (state_d == FETCH) && (cnt_d < CNT_END);
        rd_addr_d    = rd_en_d ? gen_rd_addr : rd_addr_q;
        conv_start_d = (state_d == CONV);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers; reset aborts a pass immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            conv_a_q     <= '0;
            conv_b_q     <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_all_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            r_q          <= r_d;
            c_q          <= c_d;
            conv_a_q     <= conv_a_d;
            conv_b_q     <= conv_b_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            done_all_q   <= done_all_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign conv_a     = conv_a_q;
    assign conv_b     = conv_b_q;
    assign conv_start = conv_start_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done_all   = done_all_q;

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (>=5).
REQ-002 SHALL have parameter IMG_H, default 8, image height in pixels (>=5).
REQ-003 SHALL have parameter ADDR_W, default 16, pixel-memory address width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port go  input  1  start one full-image pass (sampled in IDLE only).
REQ-007 SHALL have port filter_in  input  200  25 signed 8-bit taps, tap k at [k*8+:8].
REQ-008 SHALL have ports rd_en output 1, rd_addr output ADDR_W, rd_data input 8: source pixel memory, 1-cycle read latency.
REQ-009 SHALL have ports conv_a output 200, conv_b output 200, conv_start output 1: drive the 25-tap convolution unit.
REQ-010 SHALL have ports conv_done input 1, conv_result input 8, conv_sign input 1: convolution unit outputs.
REQ-011 SHALL have ports wr_en output 1, wr_addr output ADDR_W, wr_data output 8: destination memory write.
REQ-012 SHALL have ports busy output 1 (high outside IDLE) and done_all output 1 (one-cycle pulse at pass end).

Function
REQ-013 SHALL implement states IDLE, FETCH, CONV, WRITE, ADVANCE, FINISH.
REQ-014 IDLE: on go=1, SHALL latch filter_in into conv_b, clear x,y to 0, enter FETCH; go in any other state SHALL be ignored.
REQ-015 FETCH: SHALL assert rd_en for exactly 25 consecutive cycles, tap k=r*5+c at rd_addr=(y+r)*IMG_W+(x+c), k ascending.
REQ-016 SHALL store rd_data arriving one cycle after tap k's read into conv_a[k*8+:8]; FETCH lasts 26 cycles (25 issues + 1 drain).
REQ-017 CONV: SHALL hold conv_start=1 and conv_a/conv_b stable until conv_done=1; no fixed cycle count assumed.
REQ-018 WRITE: SHALL pulse wr_en one cycle with wr_addr=y*(IMG_W-4)+x, wr_data=conv_result (saturated magnitude); conv_start SHALL be 0 here.
REQ-019 ADVANCE: x increments; at x=IMG_W-5, x wraps to 0 and y increments; after (IMG_W-5, IMG_H-5) go to FINISH, else FETCH.
REQ-020 FINISH: SHALL pulse done_all one cycle, then return to IDLE.
REQ-021 Only interior outputs are produced: (IMG_W-4)*(IMG_H-4) writes per pass, in row-major order.
REQ-022 conv_start SHALL be low for at least one cycle between consecutive windows so the unit restarts.
REQ-023 conv_sign SHALL be ignored except by the optional feature below.

Reset
REQ-024 reset=1 SHALL immediately force IDLE; rd_en, wr_en, conv_start, busy, done_all=0; conv_a, conv_b, rd_addr, wr_addr, wr_data, x, y=0.
REQ-025 reset mid-pass SHALL abort without a further write; next go restarts from pixel (0,0).

Configuration
REQ-026 With CONV_SCHED_NEG_CLAMP_EN defined, wr_data SHALL be 0 when conv_sign=1, else conv_result.
REQ-027 Without CONV_SCHED_NEG_CLAMP_EN, wr_data SHALL equal conv_result regardless of conv_sign (absolute-value output).

Structure
REQ-028 Shared package conv_pkg SHALL hold the state enumeration and constants KSIZE=5, TAPS=25, TAP_W=8.
REQ-029 Window address generation (x,y,r,c -> rd_addr, wr_addr) SHALL be sub-module conv_addr_gen.

Verification
REQ-030 IMG_W=IMG_H=5, all pixels 1, all taps 1 -> exactly one write, wr_addr=0, wr_data=25, then done_all.
REQ-031 IMG_W=IMG_H=6, pixel=row*6+col, center tap (k=12) =1, rest 0 -> writes addr0..3 data 14,15,20,21.
REQ-032 Same image, all taps -1, flag undefined -> wr_data=|sum| (e.g. addr0 = 350 saturated to 255); flag defined -> 0.
REQ-033 go pulsed during CONV -> no effect; write count and done_all timing unchanged.
REQ-034 reset asserted in FETCH of second window -> outputs zero at once, no further wr_en; new go yields full correct pass.
REQ-035 conv_done delayed 20 cycles by model -> conv_start held high throughout, one write per window, inputs stable.
